i2c_slave_regfile: RTL and testbench

I2C target (responder) with an internal byte-addressed register file. It answers the bus master's address/memory-address/data transactions and lets an APB-side or test-side observer see every committed write. It sits on the far end of the SCL/SDA pair driven by the team's I2C master, oversampling both lines with the system clock. It never drives SCL.

---
 rtl/i2c_slave_regfile.sv | 211 +++++++++++++++++++++
 tb/tb_i2c_slave_regfile.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_slave_regfile.sv
// i2c_slave_regfile: I2C target with a byte-addressed register file.
// SCL/SDA are oversampled on clk; SDA is only ever pulled low (open drain).
// Build option: define I2C_SLAVE_AUTOINC_EN to advance the register pointer
// after every written byte and every ACKed read byte; otherwise the pointer
// stays fixed for the whole transaction.
module i2c_slave_regfile #(
  parameter logic [6:0] SLAVE_ADDR = 7'h42,
  parameter int         DEPTH      = 64,
  localparam int        AW         = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          scl_i,
  input  logic          sda_i,
  output logic          sda_oe,
  output logic          busy,
  output logic          wr_valid,
  output logic [AW-1:0] wr_addr,
  output logic [7:0]    wr_data
);

  localparam logic [3:0] S_IDLE      = 4'd0;
  localparam logic [3:0] S_DEV_ADDR  = 4'd1;
  localparam logic [3:0] S_DEV_ACK   = 4'd2;
  localparam logic [3:0] S_MEM_ADDR  = 4'd3;
  localparam logic [3:0] S_MEM_ACK   = 4'd4;
  localparam logic [3:0] S_WR_DATA   = 4'd5;
  localparam logic [3:0] S_WR_ACK    = 4'd6;
  localparam logic [3:0] S_RD_DATA   = 4'd7;
  localparam logic [3:0] S_RD_ACK    = 4'd8;
  localparam logic [3:0] S_WAIT_STOP = 4'd9;

  logic [1:0]    scl_sync, sda_sync;
  logic          scl_d, sda_d;
  logic          start_q, stop_q, rise_q, fall_q, sda_q;
  logic [3:0]    state;
  logic [2:0]    bit_cnt;
  logic [7:0]    shift;
  logic [AW-1:0] ptr;
  logic          rw;
  logic          ack_phase;   // ack/ack-received half of a two-fall handshake
  logic [7:0]    mem [DEPTH];
  logic [7:0]    byte_in;
  logic [7:0]    rd_byte;
  logic [AW-1:0] ptr_step;

  assign byte_in = {shift[6:0], sda_q};
  assign rd_byte = mem[ptr];

`ifdef I2C_SLAVE_AUTOINC_EN
  assign ptr_step = ptr + AW'(1);
`else
  assign ptr_step = ptr;
`endif

  // Synchronize the pads and register the bus-condition strobes.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      scl_sync <= 2'b11;
      sda_sync <= 2'b11;
      scl_d    <= 1'b1;
      sda_d    <= 1'b1;
      start_q  <= 1'b0;
      stop_q   <= 1'b0;
      rise_q   <= 1'b0;
      fall_q   <= 1'b0;
      sda_q    <= 1'b1;
    end else begin
      scl_sync <= {scl_sync[0], scl_i};
      sda_sync <= {sda_sync[0], sda_i};
      scl_d    <= scl_sync[1];
      sda_d    <= sda_sync[1];
      start_q  <= scl_sync[1] & scl_d & sda_d & ~sda_sync[1];
      stop_q   <= scl_sync[1] & scl_d & ~sda_d & sda_sync[1];
      rise_q   <= scl_sync[1] & ~scl_d;
      fall_q   <= ~scl_sync[1] & scl_d;
      sda_q    <= sda_sync[1];
    end
  end

  // Protocol FSM, register file and write-commit port.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      bit_cnt   <= '0;
      shift     <= '0;
      ptr       <= '0;
      rw        <= 1'b0;
      ack_phase <= 1'b0;
      sda_oe    <= 1'b0;
      busy      <= 1'b0;
      wr_valid  <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= '0;
      // NOTE: the register file must read 0x00 after reset, so it is built from resettable flops, not RAM.
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      wr_valid <= 1'b0;
      if (stop_q) begin
        state     <= S_IDLE;
        sda_oe    <= 1'b0;
        busy      <= 1'b0;
        bit_cnt   <= '0;
        ack_phase <= 1'b0;
      end else if (start_q) begin
        // Repeated start keeps ptr so a write-address phase can precede a read.
        state     <= S_DEV_ADDR;
        sda_oe    <= 1'b0;
        bit_cnt   <= '0;
        ack_phase <= 1'b0;
      end else begin
        case (state)
          S_IDLE: busy <= 1'b0;
          S_DEV_ADDR: if (rise_q) begin
            shift   <= byte_in;
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              if (byte_in[7:1] == SLAVE_ADDR) begin
                state <= S_DEV_ACK;
                rw    <= byte_in[0];
                busy  <= 1'b1;
              end else begin
                state <= S_WAIT_STOP;
              end
            end
          end
          S_DEV_ACK: if (fall_q) begin
            if (!ack_phase) begin
              sda_oe    <= 1'b1;
              ack_phase <= 1'b1;
            end else begin
              ack_phase <= 1'b0;
              bit_cnt   <= '0;
              if (rw) begin
                state  <= S_RD_DATA;
                shift  <= rd_byte;
                sda_oe <= ~rd_byte[7];
              end else begin
                state  <= S_MEM_ADDR;
                sda_oe <= 1'b0;
              end
            end
          end
          S_MEM_ADDR: if (rise_q) begin
            shift   <= byte_in;
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              ptr   <= byte_in[AW-1:0];
              state <= S_MEM_ACK;
            end
          end
          S_MEM_ACK, S_WR_ACK: if (fall_q) begin
            if (!ack_phase) begin
              sda_oe    <= 1'b1;
              ack_phase <= 1'b1;
            end else begin
              ack_phase <= 1'b0;
              sda_oe    <= 1'b0;
              bit_cnt   <= '0;
              state     <= S_WR_DATA;
              if (state == S_WR_ACK) ptr <= ptr_step;
            end
          end
          S_WR_DATA: if (rise_q) begin
            shift   <= byte_in;
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              mem[ptr] <= byte_in;
              wr_addr  <= ptr;
              wr_data  <= byte_in;
              wr_valid <= 1'b1;
              state    <= S_WR_ACK;
            end
          end
          S_RD_DATA: if (fall_q) begin
            // MSB went out on entry; each later fall presents the next bit.
            if (bit_cnt == 3'd7) begin
              sda_oe    <= 1'b0;
              bit_cnt   <= '0;
              ack_phase <= 1'b0;
              state     <= S_RD_ACK;
            end else begin
              shift   <= {shift[6:0], 1'b0};
              sda_oe  <= ~shift[6];
              bit_cnt <= bit_cnt + 3'd1;
            end
          end
          S_RD_ACK: begin
            if (rise_q && !ack_phase) begin
              if (sda_q) begin
                state <= S_WAIT_STOP;
              end else begin
                ack_phase <= 1'b1;
                ptr       <= ptr_step;
              end
            end else if (fall_q && ack_phase) begin
              ack_phase <= 1'b0;
              shift     <= rd_byte;
              sda_oe    <= ~rd_byte[7];
              state     <= S_RD_DATA;
            end
          end
          S_WAIT_STOP: sda_oe <= 1'b0;
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2c_slave_regfile.sv
// Testbench for i2c_slave_regfile: bit-banged I2C master, array reference
// model of the register file, and a scoreboard fed by every write issued.
`timescale 1ns/1ps
module tb_i2c_slave_regfile;

  localparam logic [6:0] ADDR  = 7'h42;
  localparam int         DEPTH = 64;
  localparam int         AW    = $clog2(DEPTH);
  localparam int         Q     = 5;   // quarter SCL period in clk cycles
`ifdef I2C_SLAVE_AUTOINC_EN
  localparam bit AUTOINC = 1'b1;
`else
  localparam bit AUTOINC = 1'b0;
`endif

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [7:0]    data;
  } wr_t;

  logic          clk = 1'b0;
  logic          reset;
  logic          scl = 1'b1;
  logic          sda_m = 1'b1;
  logic          sda_pad;
  logic          sda_oe;
  logic          busy;
  logic          wr_valid;
  logic [AW-1:0] wr_addr;
  logic [7:0]    wr_data;

  int            checks = 0;
  int            errors = 0;
  logic [7:0]    model_mem [DEPTH];
  wr_t           exp_q [$];
  wr_t           exp_e;
  logic [7:0]    wbuf [$];

  assign sda_pad = sda_m & ~sda_oe;

  i2c_slave_regfile #(.SLAVE_ADDR(ADDR), .DEPTH(DEPTH)) dut (
    .clk      (clk),
    .reset    (reset),
    .scl_i    (scl),
    .sda_i    (sda_pad),
    .sda_oe   (sda_oe),
    .busy     (busy),
    .wr_valid (wr_valid),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data)
  );

  always #5 clk = ~clk;

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: every committed write must match the oldest expected one.
  always @(negedge clk) begin
    if (wr_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("wr_unexpected", wr_valid, 0);
      end else begin
        exp_e = exp_q.pop_front();
        check("wr_addr", wr_addr, exp_e.addr);
        check("wr_data", wr_data, exp_e.data);
      end
    end
  end

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bit(input logic b, output logic seen);
    wait_clk(Q); sda_m = b;
    wait_clk(Q); scl = 1'b1;
    wait_clk(Q); seen = sda_pad;
    wait_clk(Q); scl = 1'b0;
  endtask

  task automatic bus_start();
    wait_clk(2*Q); sda_m = 1'b0;
    wait_clk(2*Q); scl = 1'b0;
  endtask

  task automatic bus_rstart();
    wait_clk(Q); sda_m = 1'b1;
    wait_clk(Q); scl = 1'b1;
    wait_clk(2*Q); sda_m = 1'b0;
    wait_clk(2*Q); scl = 1'b0;
  endtask

  task automatic bus_stop();
    wait_clk(Q); sda_m = 1'b0;
    wait_clk(Q); scl = 1'b1;
    wait_clk(2*Q); sda_m = 1'b1;
    wait_clk(2*Q);
  endtask

  task automatic send_byte(input logic [7:0] v, output logic ack);
    logic s;
    for (int i = 7; i >= 0; i--) send_bit(v[i], s);
    send_bit(1'b1, ack);
  endtask

  task automatic recv_byte(output logic [7:0] v, input logic nack, output logic seen);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      send_bit(1'b1, b);
      v[i] = b;
    end
    send_bit(nack, seen);
  endtask

  // Write the bytes in wbuf starting at register ra on device dev.
  task automatic write_txn(input logic [6:0] dev, input logic [7:0] ra, input bit do_stop);
    logic          ack;
    logic [AW-1:0] p;
    bit            hit;
    hit = (dev == ADDR);
    bus_start();
    send_byte({dev, 1'b0}, ack);
    check("dev_ack", ack, hit ? 0 : 1);
    check("busy_after_addr", busy, hit);
    send_byte(ra, ack);
    check("mem_ack", ack, hit ? 0 : 1);
    p = ra[AW-1:0];
    foreach (wbuf[i]) begin
      if (hit) begin
        model_mem[p] = wbuf[i];
        exp_q.push_back('{p, wbuf[i]});
        if (AUTOINC) p = p + AW'(1);
      end
      send_byte(wbuf[i], ack);
      check("data_ack", ack, hit ? 0 : 1);
    end
    if (do_stop) begin
      bus_stop();
      check("busy_after_stop", busy, 0);
    end
  endtask

  // Set the pointer, repeated START, read n bytes (NACK on the last), STOP.
  task automatic read_txn(input logic [7:0] ra, input int n);
    logic          ack, seen, last;
    logic [7:0]    v;
    logic [AW-1:0] p;
    wbuf.delete();
    write_txn(ADDR, ra, 1'b0);
    bus_rstart();
    send_byte({ADDR, 1'b1}, ack);
    check("rd_dev_ack", ack, 0);
    p = ra[AW-1:0];
    for (int i = 0; i < n; i++) begin
      last = (i == n - 1);
      recv_byte(v, last, seen);
      check("rd_data", v, model_mem[p]);
      if (last) check("rd_release", seen, 1);
      else if (AUTOINC) p = p + AW'(1);
    end
    bus_stop();
    check("busy_after_stop", busy, 0);
  endtask

  initial begin
    logic       s;
    logic [7:0] b8;
    for (int i = 0; i < DEPTH; i++) model_mem[i] = 8'h00;
    reset = 1'b1;
    wait_clk(3);
    reset = 1'b0;
    wait_clk(2);
    check("reset_sda_oe", sda_oe, 0);
    check("reset_busy", busy, 0);
    check("reset_wr_valid", wr_valid, 0);
    check("reset_wr_addr", wr_addr, 0);
    check("reset_wr_data", wr_data, 0);

    // Single write then read-back through repeated START.
    wbuf = '{8'hA5};
    write_txn(ADDR, 8'h10, 1'b1);
    read_txn(8'h10, 1);

    // Wrong device: nothing acked, nothing committed, busy stays low.
    wbuf = '{8'h55, 8'h66};
    write_txn(7'h43, 8'h20, 1'b1);

    // Burst across the top of the register file.
    wbuf = '{8'h11, 8'h22};
    write_txn(ADDR, 8'h3F, 1'b1);
    read_txn(8'h3F, 1);
    read_txn(8'h00, 1);

    // STOP after 5 data bits: partial byte discarded.
    wbuf.delete();
    write_txn(ADDR, 8'h05, 1'b0);
    for (int i = 0; i < 5; i++) send_bit(1'b1, s);
    bus_stop();
    check("busy_partial_stop", busy, 0);
    read_txn(8'h05, 1);

    // Randomized bursts checked against the model.
    for (int t = 0; t < 12; t++) begin
      logic [7:0] ra;
      int         n;
      ra = 8'($urandom_range(0, 255));
      n  = $urandom_range(1, 3);
      wbuf.delete();
      for (int i = 0; i < n; i++) wbuf.push_back(8'($urandom_range(0, 255)));
      write_txn(ADDR, ra, 1'b1);
      read_txn(8'($urandom_range(0, 255)), $urandom_range(1, 3));
      read_txn(ra, n);
    end

    // Reset while the slave is driving the address ack.
    b8 = {ADDR, 1'b0};
    bus_start();
    for (int i = 7; i >= 0; i--) send_bit(b8[i], s);
    for (int k = 0; k < 20 && sda_oe !== 1'b1; k++) @(negedge clk);
    check("ack_driven_before_reset", sda_oe, 1);
    #1 reset = 1'b1;
    #1;
    check("sda_oe_async_reset", sda_oe, 0);
    check("busy_async_reset", busy, 0);
    wait_clk(2);
    reset = 1'b0;
    for (int i = 0; i < DEPTH; i++) model_mem[i] = 8'h00;
    wait_clk(2);
    sda_m = 1'b1;
    wait_clk(Q);
    scl = 1'b1;
    wait_clk(2*Q);
    read_txn(8'h10, 1);
    read_txn(8'h3F, 1);

    wait_clk(4);
    check("scoreboard_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
